// File: rtl/life_grid.sv
// Life-like cellular automaton engine: W x H grid, programmable birth/survive
// masks, toroidal or dead edges, serial seeding and per-step population count.
// Ports: clk, reset_n (async, active-low); seed_ena/seed_bit shift a seed in;
// step_req starts one generation; rule_birth/rule_survive select the rule;
// grid_out (index r*W+c), step_busy, step_done, generation, population,
// pop_valid, stable, extinct report status.
module life_grid #(
  parameter int W     = 8,
  parameter int H     = 8,
  parameter int TORUS = 1,
  parameter int GEN_W = 16,
  parameter int POP_W = $clog2(W*H+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_ena,
  input  logic             seed_bit,
  input  logic             step_req,
  input  logic [8:0]       rule_birth,
  input  logic [8:0]       rule_survive,
  output logic [W*H-1:0]   grid_out,
  output logic             step_busy,
  output logic             step_done,
  output logic [GEN_W-1:0] generation,
  output logic [POP_W-1:0] population,
  output logic             pop_valid,
  output logic             stable,
  output logic             extinct
);

  localparam int N  = W * H;
  localparam int RW = $clog2(H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_COUNT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_grid;
  logic [RW-1:0]    r_row;
  logic [POP_W-1:0] r_acc;
  logic [POP_W-1:0] r_pop;
  logic [GEN_W-1:0] r_gen;
  logic             r_done;
  logic             r_pv;
  logic             r_stable;
  logic             r_extinct;

  logic [N-1:0]     w_next;
  logic [W-1:0]     w_row;
  logic [POP_W-1:0] w_rowpop;

  // Live neighbours of cell (r,c); wraps on a torus, else off-grid is dead.
  function automatic logic [3:0] f_nbrs(
    input logic [N-1:0] g,
    input int           r,
    input int           c
  );
    logic [3:0] n;
    int         rr;
    int         cc;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          rr = r + dr;
          cc = c + dc;
          if (TORUS != 0) begin
            rr = (rr + H) % H;
            cc = (cc + W) % W;
            n  = n + {3'b000, g[rr*W+cc]};
          end else if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
            n = n + {3'b000, g[rr*W+cc]};
          end
        end
      end
    end
    return n;
  endfunction

  for (genvar gr = 0; gr < H; gr++) begin : g_row
    for (genvar gc = 0; gc < W; gc++) begin : g_col
      logic [3:0] w_cnt;
      assign w_cnt = f_nbrs(r_grid, gr, gc);
      assign w_next[gr*W+gc] = r_grid[gr*W+gc] ?
        rule_survive[w_cnt] : rule_birth[w_cnt];
    end
  end

  always_comb begin
    w_row    = '0;
    w_rowpop = '0;
    for (int k = 0; k < H; k++) begin
      if (r_row == RW'(k)) w_row = r_grid[k*W +: W];
    end
    for (int j = 0; j < W; j++) begin
      w_rowpop = w_rowpop + POP_W'(w_row[j]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grid    <= '0;
      r_row     <= '0;
      r_acc     <= '0;
      r_pop     <= '0;
      r_gen     <= '0;
      r_done    <= 1'b0;
      r_pv      <= 1'b0;
      r_stable  <= 1'b0;
      r_extinct <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (seed_ena) begin
            r_grid    <= {r_grid[N-2:0], seed_bit};
            r_gen     <= '0;
            r_pv      <= 1'b0;
            r_stable  <= 1'b0;
            r_extinct <= 1'b0;
          end else if (step_req) begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_grid   <= w_next;
          r_stable <= (w_next == r_grid);
          r_gen    <= r_gen + 1'b1;
          r_pv     <= 1'b0;
          r_acc    <= '0;
          r_row    <= '0;
          r_state  <= S_COUNT;
        end
        S_COUNT: begin
          r_acc <= r_acc + w_rowpop;
          if (r_row == RW'(H-1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        S_DONE: begin
          r_pop     <= r_acc;
          r_pv      <= 1'b1;
          r_extinct <= (r_acc == '0);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grid_out   = r_grid;
  assign step_busy  = (r_state != S_IDLE);
  assign step_done  = r_done;
  assign generation = r_gen;
  assign population = r_pop;
  assign pop_valid  = r_pv;
  assign stable     = r_stable;
  assign extinct    = r_extinct;

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: 5x5 torus and dead-edge instances in lockstep,
// blinker/block/glider/HighLife patterns, collisions and mid-step reset.
module tb_life_grid;

  logic        clk;
  logic        reset_n;
  logic        seed_ena;
  logic        seed_bit;
  logic        step_req;
  logic [8:0]  rule_birth;
  logic [8:0]  rule_survive;

  logic [24:0] grid_t, grid_d;
  logic        busy_t, busy_d;
  logic        done_t, done_d;
  logic [15:0] gen_t, gen_d;
  logic [4:0]  pop_t, pop_d;
  logic        pv_t, pv_d;
  logic        stab_t, stab_d;
  logic        ext_t, ext_d;

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int pulses;

  life_grid #(.W(5), .H(5), .TORUS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .seed_ena(seed_ena), .seed_bit(seed_bit), .step_req(step_req),
    .rule_birth(rule_birth), .rule_survive(rule_survive),
    .grid_out(grid_t), .step_busy(busy_t), .step_done(done_t),
    .generation(gen_t), .population(pop_t), .pop_valid(pv_t),
    .stable(stab_t), .extinct(ext_t)
  );

  life_grid #(.W(5), .H(5), .TORUS(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .seed_ena(seed_ena), .seed_bit(seed_bit), .step_req(step_req),
    .rule_birth(rule_birth), .rule_survive(rule_survive),
    .grid_out(grid_d), .step_busy(busy_d), .step_done(done_d),
    .generation(gen_d), .population(pop_d), .pop_valid(pv_d),
    .stable(stab_d), .extinct(ext_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic seed_grid(input logic [24:0] p);
    for (int i = 24; i >= 0; i--) begin
      seed_ena = 1'b1;
      seed_bit = p[i];
      @(negedge clk);
    end
    seed_ena = 1'b0;
    seed_bit = 1'b0;
  endtask

  task automatic do_step(output int l);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    l = 1;
    while (!done_t && l < 50) begin
      @(negedge clk);
      l++;
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    seed_ena     = 1'b0;
    seed_bit     = 1'b0;
    step_req     = 1'b0;
    rule_birth   = 9'h008;
    rule_survive = 9'h00C;
    @(negedge clk);
    @(negedge clk);
    check("rst_grid", 32'(grid_t), 32'h0);
    check("rst_busy", 32'(busy_t), 32'h0);
    check("rst_done", 32'(done_t), 32'h0);
    check("rst_gen", 32'(gen_t), 32'h0);
    check("rst_pop", 32'(pop_t), 32'h0);
    check("rst_flags", {29'b0, pv_t, stab_t, ext_t}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    seed_grid(25'h0003800);
    check("blk_seed", 32'(grid_t), 32'h3800);
    check("blk_seed_pv", 32'(pv_t), 32'h0);
    do_step(lat);
    check("blink_lat", lat, 7);
    check("blink_grid", 32'(grid_t), 32'h21080);
    check("blink_grid0", 32'(grid_d), 32'h21080);
    check("blink_pop", 32'(pop_t), 32'd3);
    check("blink_stab", 32'(stab_t), 32'h0);
    check("blink_gen", 32'(gen_t), 32'd1);
    check("blink_pv", 32'(pv_t), 32'h1);
    check("blink_busy", 32'(busy_t), 32'h0);
    do_step(lat);
    check("blink2_grid", 32'(grid_t), 32'h3800);
    check("blink2_gen", 32'(gen_t), 32'd2);

    seed_grid(25'h00018C0);
    do_step(lat);
    check("block_grid", 32'(grid_t), 32'h18C0);
    check("block_stab", 32'(stab_t), 32'h1);
    check("block_pop", 32'(pop_t), 32'd4);
    check("block_ext", 32'(ext_t), 32'h0);
    do_step(lat);
    check("block2_stab", 32'(stab_t), 32'h1);
    check("block2_pop", 32'(pop_t), 32'd4);

    seed_grid(25'h0001C82);
    for (int s = 0; s < 20; s++) do_step(lat);
    check("glider_t_grid", 32'(grid_t), 32'h1C82);
    check("glider_t_pop", 32'(pop_t), 32'd5);
    check("glider_t_gen", 32'(gen_t), 32'd20);
    check("glider_d_grid", 32'(grid_d), 32'h18C0000);
    check("glider_d_pop", 32'(pop_d), 32'd4);
    check("glider_d_stab", 32'(stab_d), 32'h1);
    check("glider_d_gen", 32'(gen_d), 32'd20);

    seed_ena = 1'b1;
    seed_bit = 1'b1;
    step_req = 1'b1;
    @(negedge clk);
    seed_ena = 1'b0;
    seed_bit = 1'b0;
    step_req = 1'b0;
    check("coll_grid", 32'(grid_t), 32'h3905);
    check("coll_busy", 32'(busy_t), 32'h0);
    check("coll_gen", 32'(gen_t), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("coll_busy2", 32'(busy_t), 32'h0);
    check("coll_grid2", 32'(grid_t), 32'h3905);

    rule_birth = 9'h048;
    seed_grid(25'h0000001);
    do_step(lat);
    check("hl_grid", 32'(grid_t), 32'h0);
    check("hl_pop", 32'(pop_t), 32'h0);
    check("hl_ext", 32'(ext_t), 32'h1);
    check("hl_stab", 32'(stab_t), 32'h0);
    rule_birth = 9'h008;

    seed_grid(25'h0003800);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    pulses = 0;
    repeat (20) begin
      if (done_t) pulses++;
      @(negedge clk);
    end
    check("cnt_req_pulses", pulses, 1);
    check("cnt_req_gen", 32'(gen_t), 32'd1);
    check("cnt_req_grid", 32'(grid_t), 32'h21080);
    check("cnt_req_busy", 32'(busy_t), 32'h0);

    seed_grid(25'h0003800);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    pulses = 0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_grid", 32'(grid_t), 32'h0);
    check("mid_rst_busy", 32'(busy_t), 32'h0);
    check("mid_rst_gen", 32'(gen_t), 32'h0);
    repeat (12) begin
      if (done_t) pulses++;
      @(negedge clk);
    end
    check("mid_rst_pulses", pulses, 0);
    seed_grid(25'h00018C0);
    do_step(lat);
    check("post_rst_lat", lat, 7);
    check("post_rst_grid", 32'(grid_t), 32'h18C0);
    check("post_rst_pop", 32'(pop_t), 32'd4);
    check("post_rst_gen", 32'(gen_t), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/life_grid.md
Name: life_grid

Overview:
- Parametrised W x H Game-of-Life array: a generalisation of the single life cell to a full grid engine.
- Holds its own cell state and steps one generation per request.
- Life-like rule is programmable at run time (birth/survive masks); edges are either toroidal or dead.
- After each step the block counts population serially and flags stable/extinct grids, feeding the display/scan logic and the game controller.

Parameters:
- W, 8, grid width in cells (>=3).
- H, 8, grid height in cells (>=3).
- TORUS, 1, 1 = edges wrap (toroidal); 0 = cells outside the grid are dead.
- GEN_W, 16, generation counter width.
- POP_W, $clog2(W*H+1), population counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- seed_ena  in  1  shift seed_bit into the grid this cycle.
- seed_bit  in  1  serial seed data.
- step_req  in  1  request one generation step.
- rule_birth  in  9  bit n=1: a dead cell with n live neighbours is born.
- rule_survive  in  9  bit n=1: a live cell with n live neighbours survives.
- grid_out  out  W*H  cell state; index r*W+c, row 0 first.
- step_busy  out  1  high while a step/count is in progress.
- step_done  out  1  one-cycle pulse when a step completes.
- generation  out  GEN_W  generations since the last seed.
- population  out  POP_W  live-cell count.
- pop_valid  out  1  population reflects grid_out.
- stable  out  1  last step produced no change.
- extinct  out  1  population==0 after the last step.

Behaviour:
- Reset (async, reset_n=0): grid cleared; FSM enters IDLE; generation=0; population=0; step_busy, step_done, pop_valid, stable and extinct all 0. Reset asserted mid-step aborts the step immediately.
- FSM states: IDLE -> CALC -> COUNT -> DONE -> IDLE. step_busy = (state != IDLE).
- IDLE:
  - seed_ena=1: grid[0] <= seed_bit; grid[i] <= grid[i-1] for i>0; grid[W*H-1] is discarded.
  - Each seed cycle also clears generation, pop_valid, stable and extinct.
  - seed_ena has priority over step_req in the same cycle; that step_req is dropped, not queued.
  - step_req=1 with seed_ena=0: go to CALC.
- seed_ena and step_req are ignored in every state except IDLE.
- CALC (1 cycle):
  - For every cell, n = count of 8 neighbours (0..8).
  - Neighbour indexing: TORUS=1 uses rows/cols modulo H/W; TORUS=0 treats out-of-range neighbours as 0.
  - next = alive ? rule_survive[n] : rule_birth[n]. Rules are sampled in this cycle only.
  - All cells update simultaneously at the closing edge.
  - stable <= (next grid == current grid); generation <= generation+1 (wraps modulo 2^GEN_W); pop_valid <= 0.
- COUNT (H cycles): row k is counted in cycle k, adding popcount(row k) to an internal accumulator cleared on entry.
- DONE (1 cycle):
  - step_done=1; population <= accumulator; pop_valid <= 1; extinct <= (accumulator==0).
  - Next state is IDLE.
- Latency: step_req sampled at edge t -> grid_out updated at edge t+1 -> step_done high during cycle t+H+2; a new step_req is accepted from cycle t+H+3.
- A step while pop_valid=0 (just after seeding) is legal; population becomes valid at the following DONE.
- Edge case: n=8 is reachable only when TORUS=1 or for interior cells; both mask bits 8 are honoured.

Test Plan:
- W=H=5, TORUS=1, Conway rules (birth=9'h008, survive=9'h00C). Seed a horizontal blinker in row 2, cols 1..3, then step. Required: a vertical blinker at rows 1..3, col 2; population=3; stable=0; generation=1; step_done exactly H+2 cycles after step_req.
- Same setup with a 2x2 block still life. Required: after each step stable=1, population=4, extinct=0.
- W=H=5, glider, 20 steps. TORUS=1: glider reappears at its seeded position after exactly 20 generations. TORUS=0: the glider collapses into a 2x2 block at the corner; population=4, stable=1.
- HighLife rules (birth=9'h048, survive=9'h00C), seed a single live cell. Required: after one step grid all zero, population=0, extinct=1.
- Collision checks:
  - seed_ena and step_req asserted together in IDLE: seed shifts, no step starts, step_busy stays 0.
  - step_req during COUNT: ignored; only one step_done pulse.
- Pull reset_n low for 1 cycle mid-COUNT. Required: grid_out=0, state IDLE, step_done never pulses, generation=0; a subsequent seed and step proceed normally.
